// File: rtl/fp_alu_add.sv
// Binary32 adder: round-to-nearest-even, subnormal inputs/outputs flushed to zero, 1-cycle registered result.
// Define FPALU_ADD_OVERFLOW_EN to add the registered finite-overflow flag output.
module fp_alu_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
`ifdef FPALU_ADD_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Operand decode
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

  assign sign_a = a[31];
  assign sign_b = b[31];
  assign exp_a  = a[30:23];
  assign exp_b  = b[30:23];
  assign frac_a = a[22:0];
  assign frac_b = b[22:0];
  assign zero_a = (exp_a == 8'h00);
  assign zero_b = (exp_b == 8'h00);
  assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

  logic        special;
  logic [31:0] special_res;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    special     = 1'b1;
    special_res = 32'h0000_0000;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) special_res = QNAN;
    else if (inf_a)                                                 special_res = a;
    else if (inf_b)                                                 special_res = b;
    else if (zero_a && zero_b)                                      special_res = {sign_a & sign_b, 31'd0};
    else if (zero_a)                                                special_res = b;
    else if (zero_b)                                                special_res = a;
    else                                                            special     = 1'b0;
  end

  // Order by magnitude; ties pick A, which makes exact cancellation symmetric.
  logic        a_big;
  logic        sign_big;
  logic [7:0]  exp_big, exp_sml, exp_diff;
  logic [23:0] man_big, man_sml;

  assign a_big    = {exp_a, frac_a} >= {exp_b, frac_b};
  assign sign_big = a_big ? sign_a : sign_b;
  assign exp_big  = a_big ? exp_a  : exp_b;
  assign exp_sml  = a_big ? exp_b  : exp_a;
  assign man_big  = a_big ? {1'b1, frac_a} : {1'b1, frac_b};
  assign man_sml  = a_big ? {1'b1, frac_b} : {1'b1, frac_a};
  assign exp_diff = exp_big - exp_sml;

  // aligned = {24-bit significand, guard, round}; everything below folds into align_sticky.
  logic [49:0] shift_wide;
  logic [25:0] aligned;
  logic        align_sticky;

  always_comb begin
    shift_wide = {man_sml, 26'd0} >> exp_diff;
    if (exp_diff >= 8'd26) begin
      aligned      = 26'd0;
      align_sticky = 1'b1;
    end else begin
      aligned      = shift_wide[49:24];
      align_sticky = |shift_wide[23:0];
    end
  end

  logic        eff_sub;
  logic [26:0] sum_raw, diff_raw, pre_norm;
  logic        carry;

  assign eff_sub  = sign_a ^ sign_b;
  assign sum_raw  = {1'b0, man_big, 2'b00} + {1'b0, aligned};
  // Sticky takes part in the subtraction as a third low bit so the borrow keeps rounding exact.
  assign diff_raw = {man_big, 3'b000} - {aligned, align_sticky};

  // pre_norm = {24-bit significand, guard, round, sticky}
  always_comb begin
    carry    = 1'b0;
    pre_norm = {sum_raw[25:0], align_sticky};
    if (eff_sub) begin
      pre_norm = diff_raw;
    end else if (sum_raw[26]) begin
      carry    = 1'b1;
      pre_norm = {sum_raw[26:1], sum_raw[0] | align_sticky};
    end
  end

  logic        cancel;
  logic [4:0]  lzc;
  logic [26:0] norm;
  logic signed [9:0] exp_norm, exp_rnd;

  assign cancel = (pre_norm == 27'd0);

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (pre_norm[3+i]) lzc = 5'(23 - i);
    end
  end

  assign norm     = pre_norm << lzc;
  assign exp_norm = {2'b00, exp_big} + {9'd0, carry} - {5'd0, lzc};

  logic        round_up;
  logic [24:0] man_rnd;
  logic [22:0] frac_rnd;

  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign man_rnd  = {1'b0, norm[26:3]} + {24'd0, round_up};
  assign exp_rnd  = exp_norm + {9'd0, man_rnd[24]};
  assign frac_rnd = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];

  logic [31:0] s_d, s_q;

  always_comb begin
    s_d = {sign_big, exp_rnd[7:0], frac_rnd};
    if (special)                    s_d = special_res;
    else if (cancel)                s_d = 32'h0000_0000;
    else if (exp_rnd >= 10'sd255)   s_d = {sign_big, 8'hFF, 23'd0};
    else if (exp_rnd <= 10'sd0)     s_d = {sign_big, 31'd0};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= 32'h0000_0000;
    else        s_q <= s_d;
  end

  assign s = s_q;

`ifdef FPALU_ADD_OVERFLOW_EN
  logic overflow_d, overflow_q;

  assign overflow_d = !special && !cancel && (exp_rnd >= 10'sd255);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_fp_alu_add.sv
// Self-checking bench for fp_alu_add: directed corner vectors plus random operands against a real-arithmetic model.
// Build with FPALU_ADD_OVERFLOW_EN defined to also check the overflow flag.
module tb_fp_alu_add;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, s;
`ifdef FPALU_ADD_OVERFLOW_EN
  logic        overflow;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_alu_add dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
`ifdef FPALU_ADD_OVERFLOW_EN
    .overflow (overflow),
`endif
    .s        (s)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        ovf;
  } vec_t;

  // Reference model: exact-enough real arithmetic, then rounding to binary32.
  // A 53-bit double holds the sum of two binary32 values well enough that a second RNE rounding is correct.
  function automatic real f32_to_real(input logic [31:0] x);
    logic [10:0] de;
    de = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], de, x[22:0], 29'd0});
  endfunction

  function automatic logic [32:0] real_to_f32(input real v);
    logic [63:0] bits;
    logic [24:0] sig;
    logic [28:0] tail;
    int          e;
    int          fe;
    bits = $realtobits(v);
    if (bits[62:0] == 63'd0) return {1'b0, bits[63], 31'd0};
    e    = int'(bits[62:52]) - 1023;
    sig  = {2'b01, bits[51:29]};
    tail = bits[28:0];
    if (tail > 29'h1000_0000 || (tail == 29'h1000_0000 && sig[0])) sig = sig + 25'd1;
    if (sig[24]) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    fe = e + 127;
    if (fe >= 255) return {1'b1, bits[63], 8'hFF, 23'd0};
    if (fe <= 0)   return {1'b0, bits[63], 31'd0};
    return {1'b0, bits[63], 8'(fe), sig[22:0]};
  endfunction

  // Returns {overflow, sum}.
  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic nan_x, nan_y, inf_x, inf_y, zx, zy;
    nan_x = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    nan_y = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    inf_x = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    inf_y = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    zx    = (x[30:23] == 8'h00);
    zy    = (y[30:23] == 8'h00);
    if (nan_x || nan_y)                     return {1'b0, QNAN};
    if (inf_x && inf_y && (x[31] != y[31])) return {1'b0, QNAN};
    if (inf_x)                              return {1'b0, x};
    if (inf_y)                              return {1'b0, y};
    if (zx && zy)                           return {1'b0, x[31] & y[31], 31'd0};
    if (zx)                                 return {1'b0, y};
    if (zy)                                 return {1'b0, x};
    return real_to_f32(f32_to_real(x) + f32_to_real(y));
  endfunction

  // Random operand, biased toward corners; some picks are built from the partner to force cancellation.
  function automatic logic [31:0] rand_f32(input logic [31:0] partner);
    logic        sg;
    logic [7:0]  ex;
    logic [22:0] fr;
    int          kind;
    sg   = 1'($urandom_range(0, 1));
    ex   = 8'($urandom_range(1, 254));
    fr   = 23'($urandom);
    kind = int'($urandom_range(0, 15));
    case (kind)
      0:       return {sg, 31'd0};
      1:       return {sg, 8'hFF, 23'd0};
      2:       return {sg, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      3:       return {sg, 8'h00, fr};
      4:       return {sg, 8'($urandom_range(250, 254)), fr};
      5:       return {sg, 8'($urandom_range(1, 4)), fr};
      6, 7:    return {~partner[31], partner[30:23], partner[22:0] ^ 23'($urandom_range(0, 255))};
      8:       return {~partner[31], partner[30:23] - 8'd1, fr};
      default: return {sg, ex, fr};
    endcase
  endfunction

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] exp_v;
    rst_n = 1'b0;
    a     = 32'h3F80_0000;
    b     = 32'h4000_0000;
    #2;
    checks++;
    if (s !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_async: s=%h expected 00000000", s);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_hold: s=%h expected 00000000", s);
    end
`ifdef FPALU_ADD_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf: overflow=%b expected 0", overflow);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_v = ref_add(a, b);
    #1;
    checks++;
    if (s !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_release_idle: s=%h expected 00000000", s);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s !== 32'h4040_0000 || s !== exp_v[31:0]) begin
      failures++;
      $display("FAIL reset_first_capture: s=%h expected 40400000", s);
    end
  endtask

  task automatic test_directed();
    vec_t tbl [20];
    tbl = '{
      '{32'h0DEEEE00, 32'h0DEE0000, 32'h0E6E7700, 1'b0},
      '{32'hF5550005, 32'h7555000D, 32'h6B000000, 1'b0},
      '{32'hC0FFFFFF, 32'h40FFFFFF, 32'h00000000, 1'b0},
      '{32'hD5551255, 32'hD5551250, 32'hD5D51252, 1'b0},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0},
      '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0},
      '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0},
      '{32'h00000000, 32'hC0490FDB, 32'hC0490FDB, 1'b0},
      '{32'h00000000, 32'h80000000, 32'h00000000, 1'b0},
      '{32'h80000000, 32'h80000000, 32'h80000000, 1'b0},
      '{32'h00800001, 32'h80800000, 32'h00000000, 1'b0},
      '{32'h80800001, 32'h00800000, 32'h80000000, 1'b0},
      '{32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0},
      '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0},
      '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0},
      '{32'h3F800000, 32'h32800000, 32'h3F800000, 1'b0},
      '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1},
      '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b1},
      '{32'h7F7FFFFF, 32'h72800000, 32'h7F7FFFFF, 1'b0}
    };
    for (int i = 0; i < 20; i++) begin
      drive_op(tbl[i].a, tbl[i].b);
      checks++;
      if (s !== tbl[i].s) begin
        failures++;
        $display("FAIL directed_%0d: a=%h b=%h s=%h expected %h", i, tbl[i].a, tbl[i].b, s, tbl[i].s);
      end
`ifdef FPALU_ADD_OVERFLOW_EN
      checks++;
      if (overflow !== tbl[i].ovf) begin
        failures++;
        $display("FAIL directed_ovf_%0d: a=%h b=%h overflow=%b expected %b", i, tbl[i].a, tbl[i].b, overflow, tbl[i].ovf);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [32:0] exp_v;
    for (int i = 0; i < 600; i++) begin
      x     = rand_f32(32'h3F80_0000);
      y     = rand_f32(x);
      if (i[0]) {x, y} = {y, x};
      exp_v = ref_add(x, y);
      drive_op(x, y);
      checks++;
      if (s !== exp_v[31:0]) begin
        failures++;
        $display("FAIL random_%0d: a=%h b=%h s=%h expected %h", i, x, y, s, exp_v[31:0]);
      end
`ifdef FPALU_ADD_OVERFLOW_EN
      checks++;
      if (overflow !== exp_v[32]) begin
        failures++;
        $display("FAIL random_ovf_%0d: a=%h b=%h overflow=%b expected %b", i, x, y, overflow, exp_v[32]);
      end
`endif
    end
  endtask

  // One new operation per cycle; results are checked one cycle later from a queue.
  task automatic test_back_to_back();
    logic [32:0] exp_q [$];
    logic [32:0] exp_v;
    logic [31:0] x, y;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (s !== exp_v[31:0]) begin
          failures++;
          $display("FAIL b2b_%0d: s=%h expected %h", i - 1, s, exp_v[31:0]);
        end
`ifdef FPALU_ADD_OVERFLOW_EN
        checks++;
        if (overflow !== exp_v[32]) begin
          failures++;
          $display("FAIL b2b_ovf_%0d: overflow=%b expected %b", i - 1, overflow, exp_v[32]);
        end
`endif
      end
      if (i < 300) begin
        x = rand_f32(32'h4120_0000);
        y = rand_f32(x);
        a = x;
        b = y;
        exp_q.push_back(ref_add(x, y));
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_op(32'h7F7F_FFFF, 32'h7F7F_FFFF);
    // Mid-cycle input changes must not disturb the registered result.
    a = 32'h3F80_0000;
    b = 32'h3F80_0000;
    #1;
    checks++;
    if (s !== 32'h7F80_0000) begin
      failures++;
      $display("FAIL midcycle_hold: s=%h expected 7f800000", s);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 32'h0000_0000) begin
      failures++;
      $display("FAIL midstream_reset_async: s=%h expected 00000000", s);
    end
`ifdef FPALU_ADD_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL midstream_reset_ovf: overflow=%b expected 0", overflow);
    end
`endif
    @(posedge clk);
    #1;
    checks++;
    if (s !== 32'h0000_0000) begin
      failures++;
      $display("FAIL midstream_reset_hold: s=%h expected 00000000", s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a     = 32'h0DEE_EE00;
    b     = 32'h0DEE_0000;
    @(posedge clk);
    #1;
    checks++;
    if (s !== 32'h0E6E_7700) begin
      failures++;
      $display("FAIL midstream_first_capture: s=%h expected 0e6e7700", s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
